// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe, 2-FF row sync, per-frame snapshot, debounce, valid/ready key output.
// Key valid 1 cycle after the DEBOUNCE_FRAMES-th stable frame; an unconsumed key blocks new ones (overrun pulse).
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 27,
    parameter int SETTLE_CYCLES   = 8,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);
    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED} state_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_cols;
    logic [15:0]   r_snap;
    state_t        r_state;
    logic [CW-1:0] r_cnt, r_rel;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_overrun;

    logic          w_wrap, w_sample, w_frame_end;
    logic [15:0]   w_snap_next;
    logic [4:0]    w_ones;
    logic [3:0]    w_idx, w_code;
    logic          w_single, w_none;
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt, w_rel_nxt;
    logic [3:0]    w_cand_nxt;
    logic          w_confirm;

    assign w_wrap      = (r_dwell == DW'(SCAN_CYCLES - 1));
    assign w_sample    = (r_dwell == DW'(SETTLE_CYCLES));
    assign w_frame_end = w_wrap && (r_cols == 4'b0001);

    // Snapshot bit index is row*4+col; include the current sample so a sample on the wrap cycle is not lost.
    always_comb begin
        w_snap_next = r_snap;
        if (w_sample) begin
            for (int c = 0; c < 4; c++) begin
                if (r_cols[3-c]) begin
                    for (int r = 0; r < 4; r++) begin
                        w_snap_next[r*4+c] = r_sync2[3-r];
                    end
                end
            end
        end
    end

    always_comb begin
        w_ones = 5'd0;
        w_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap_next[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = 4'(i);
            end
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_none   = (w_ones == 5'd0);

    always_comb begin
        case (w_idx)
            4'd0:  w_code = 4'h1;  4'd1:  w_code = 4'h2;  4'd2:  w_code = 4'h3;  4'd3:  w_code = 4'hA;
            4'd4:  w_code = 4'h4;  4'd5:  w_code = 4'h5;  4'd6:  w_code = 4'h6;  4'd7:  w_code = 4'hB;
            4'd8:  w_code = 4'h7;  4'd9:  w_code = 4'h8;  4'd10: w_code = 4'h9;  4'd11: w_code = 4'hC;
            4'd12: w_code = 4'hD;  4'd13: w_code = 4'h0;  4'd14: w_code = 4'hE;  default: w_code = 4'hF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dwell <= '0;
            r_cols  <= 4'b1000;
            r_snap  <= '0;
        end else begin
            r_sync1 <= filas;
            r_sync2 <= r_sync1;
            r_snap  <= w_frame_end ? 16'h0 : w_snap_next;
            if (w_wrap) begin
                r_dwell <= '0;
                case (r_cols)
                    4'b1000: r_cols <= 4'b0100;
                    4'b0100: r_cols <= 4'b0010;
                    4'b0010: r_cols <= 4'b0001;
                    default: r_cols <= 4'b1000;
                endcase
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        w_confirm   = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_confirm   = 1'b1;
                            w_state_nxt = S_PRESSED;
                            w_rel_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = CW'(1);
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_code == r_cand)) begin
                        if (r_cnt + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
                            w_confirm   = 1'b1;
                            w_state_nxt = S_PRESSED;
                            w_cnt_nxt   = '0;
                            w_rel_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (!w_none) begin
                        w_rel_nxt = '0;
                    end else if (r_rel + CW'(1) == CW'(DEBOUNCE_FRAMES)) begin
                        w_state_nxt = S_IDLE;
                        w_rel_nxt   = '0;
                    end else begin
                        w_rel_nxt = r_rel + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_rel_nxt   = '0;
                end
            endcase
        end
    end

    // A confirm outranks the handshake: a key accepted in the confirm cycle is replaced, not dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_confirm) begin
                if (!r_key_valid || key_ready) begin
                    r_key_code  <= w_cand_nxt;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        columnas  = r_cols;
        key_code  = r_key_code;
        key_valid = r_key_valid;
        key_held  = (r_state == S_PRESSED);
        overrun   = r_overrun;
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Frame-level reference model of the keypad scanner, driven by directed and random key patterns.
module tb_keypad_scan_ctrl;
    localparam int SCAN = 4, SETTLE = 2, DF = 3, FRAME = 4 * SCAN;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    keypad_scan_ctrl #(.SCAN_CYCLES(SCAN), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .reset(reset), .filas(filas), .columnas(columnas), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] press_mask;

    // Physical keypad: row r reads high while a pressed key in that row sits on the driven column.
    always_comb begin
        filas = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_mask[r*4+c] && columnas[3-c]) filas[3-r] = 1'b1;
    end

    typedef struct {
        logic [15:0] mask;
        int          rdy;     // 0: low, 1: random, 2: high, 3: single pulse mid-frame
        int          rst_at;  // cycle in frame at which reset is asserted, -1 for none
    } frame_t;

    frame_t frames[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference state, one frame at a time.
    int          k;
    int          m_phase;     // 0 idle, 1 counting a candidate, 2 key held
    int          m_cnt, m_rel;
    logic [3:0]  m_cand;
    logic        m_vld, m_ovr, m_held;
    logic [3:0]  m_code;
    logic [63:0] keymap;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input int idx);
        logic [63:0] km;
        km = keymap;
        return km[(15 - idx) * 4 +: 4];
    endfunction

    task automatic model_reset();
        k = 0; m_phase = 0; m_cnt = 0; m_rel = 0; m_cand = 4'h0;
        m_vld = 1'b0; m_ovr = 1'b0; m_held = 1'b0; m_code = 4'h0;
    endtask

    task automatic model_edge(input logic [15:0] mask, input logic rdy);
        bit conf;
        int n, idx;
        conf = 0;
        m_ovr = 1'b0;
        k++;
        if (k % FRAME == 0) begin
            n = $countones(mask);
            idx = 0;
            for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
            case (m_phase)
                0: if (n == 1) begin
                    m_cand = code_of(idx);
                    m_cnt = 1;
                    m_phase = 1;
                    if (m_cnt == DF) begin conf = 1; m_phase = 2; m_rel = 0; m_cnt = 0; end
                end
                1: if (n == 1 && code_of(idx) == m_cand) begin
                    m_cnt++;
                    if (m_cnt == DF) begin conf = 1; m_phase = 2; m_rel = 0; m_cnt = 0; end
                end else begin
                    m_phase = 0; m_cnt = 0;
                end
                default: if (n == 0) begin
                    m_rel++;
                    if (m_rel == DF) begin m_phase = 0; m_rel = 0; end
                end else begin
                    m_rel = 0;
                end
            endcase
        end
        if (conf) begin
            if (!m_vld || rdy) begin m_code = m_cand; m_vld = 1'b1; end
            else m_ovr = 1'b1;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        m_held = (m_phase == 2);
    endtask

    task automatic check_all();
        logic [3:0] exp_cols;
        exp_cols = 4'b1000 >> ((k / SCAN) % 4);
        chk("columnas", columnas, exp_cols);
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_vld});
        chk("key_code", key_code, m_code);
        chk("key_held", {3'b0, key_held}, {3'b0, m_held});
        chk("overrun", {3'b0, overrun}, {3'b0, m_ovr});
    endtask

    task automatic add(input logic [15:0] mask, input int n, input int rdy, input int rst_at);
        frame_t f;
        for (int i = 0; i < n; i++) begin
            f.mask = mask; f.rdy = rdy; f.rst_at = (i == 0) ? rst_at : -1;
            frames.push_back(f);
        end
    endtask

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, KA = 16'h0008, K5 = 16'h0020;
    localparam logic [15:0] K9 = 16'h0400, K0 = 16'h2000, NONE = 16'h0000;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        frame_t f;
        logic [15:0] m;
        int b1;
        keymap = 64'h123A_456B_789C_D0EF;

        add(NONE, 1, 1, 7);                        // reset mid-scan
        add(NONE, 2, 1, -1);
        add(K5, 6, 0, -1);                         // held '5', no consumer
        add(K5, 1, 3, -1);                         // single ready pulse
        add(NONE, 3, 1, -1);
        add(K9, 2, 0, -1); add(NONE, 1, 0, -1); add(K9, 3, 0, -1); add(NONE, 3, 2, -1);
        add(K1 | K2, 5, 1, -1); add(NONE, 1, 1, -1);
        add(KA, 3, 0, -1); add(NONE, 3, 0, -1); add(K0, 3, 0, -1); add(NONE, 3, 0, -1);
        add(K0, 3, 2, -1); add(NONE, 3, 2, -1);
        add(K5, 2, 1, -1); add(K5, 1, 1, 6);       // reset while counting
        add(K5, 3, 1, -1); add(NONE, 3, 1, -1);
        add(K9, 4, 0, -1); add(K9, 1, 0, 3);       // reset while held
        add(K9, 2, 0, -1); add(NONE, 1, 0, -1); add(K9, 3, 2, -1); add(NONE, 3, 2, -1);

        for (int run = 0; run < 45; run++) begin
            case ($urandom_range(0, 5))
                0, 1:    m = NONE;
                5: begin
                    b1 = $urandom_range(0, 15);
                    m = (16'h1 << b1) | (16'h1 << ((b1 + $urandom_range(1, 15)) % 16));
                end
                default: m = 16'h1 << $urandom_range(0, 15);
            endcase
            add(m, $urandom_range(1, 5), $urandom_range(0, 2),
                ($urandom_range(0, 19) == 0) ? $urandom_range(1, FRAME - 1) : -1);
        end

        reset = 1'b1; press_mask = NONE; key_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        while (frames.size() > 0) begin
            f = frames.pop_front();
            press_mask = f.mask;
            for (int cyc = 1; cyc <= FRAME; cyc++) begin
                case (f.rdy)
                    0:       key_ready = 1'b0;
                    1:       key_ready = ($urandom_range(0, 3) == 0);
                    2:       key_ready = 1'b1;
                    default: key_ready = (cyc == 5);
                endcase
                @(posedge clk);
                model_edge(press_mask, key_ready);
                #1;
                check_all();
                if (cyc == f.rst_at) begin
                    reset = 1'b1;
                    key_ready = 1'b0;
                    #1;
                    model_reset();
                    check_all();
                    @(posedge clk);
                    #1;
                    check_all();
                    reset = 1'b0;
                    break;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
